// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron multiply-accumulate core: default sizes,
// FSM state encoding and the saturation limits of the default accumulator.
package neuron_pkg;

   localparam int NEURON_N = 4;
   localparam int NEURON_W = 8;
   localparam int NEURON_M = 18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam logic signed [NEURON_M-1:0] SAT_MAX = {1'b0, {(NEURON_M-1){1'b1}}};
   localparam logic signed [NEURON_M-1:0] SAT_MIN = {1'b1, {(NEURON_M-1){1'b0}}};

endpackage

// File: rtl/neuron_mac_if.sv
// Start/busy/valid handshake and operand bus between the controlling FSM
// (master) and the neuron MAC core (slave).
interface neuron_mac_if
   import neuron_pkg::*;
#(
   parameter int N = NEURON_N,
   parameter int W = NEURON_W,
   parameter int M = NEURON_M
);
   logic                 start;
   logic [N*W-1:0]       x_flat;
   logic [N*W-1:0]       w_flat;
   logic signed [M-1:0]  bias;
   logic                 busy;
   logic                 valid;
   logic signed [M-1:0]  result;

   modport master (
      output start, x_flat, w_flat, bias,
      input  busy, valid, result
   );

   modport slave (
      input  start, x_flat, w_flat, bias,
      output busy, valid, result
   );
endinterface

// File: rtl/neuron_mac_sat_add.sv
// One MAC step: acc + x*w computed in M+1 bits, then clamped to the signed
// M-bit range so an overflow pins the accumulator at the rail.
module mac_sat_add #(
   parameter int W = 8,
   parameter int M = 18
) (
   input  logic signed [M-1:0] i_acc,
   input  logic signed [W-1:0] i_x,
   input  logic signed [W-1:0] i_w,
   output logic signed [M-1:0] o_sum
);
   localparam logic signed [M:0] MAX_EXT = {2'b00, {(M-1){1'b1}}};
   localparam logic signed [M:0] MIN_EXT = {2'b11, {(M-1){1'b0}}};

   logic signed [2*W-1:0] w_prod;
   logic signed [M:0]     w_prod_ext;
   logic signed [M:0]     w_acc_ext;
   logic signed [M:0]     w_sum;

   assign w_prod     = i_x * i_w;
   assign w_prod_ext = {{(M+1-2*W){w_prod[2*W-1]}}, w_prod};
   assign w_acc_ext  = {i_acc[M-1], i_acc};
   assign w_sum      = w_prod_ext + w_acc_ext;

   // Clamp the widened sum back into the M-bit signed range.
   always_comb begin
      o_sum = w_sum[M-1:0];
      if (w_sum > MAX_EXT) begin
         o_sum = MAX_EXT[M-1:0];
      end else if (w_sum < MIN_EXT) begin
         o_sum = MIN_EXT[M-1:0];
      end else begin
         o_sum = w_sum[M-1:0];
      end
   end
endmodule

// File: rtl/neuron_mac.sv
// Sequential neuron MAC: bias + sum x[i]*w[i], one product per clock, with
// per-step saturation, optional ReLU and a one-cycle valid pulse.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int N   = NEURON_N,
   parameter int W   = NEURON_W,
   parameter int M   = NEURON_M,
   parameter int ACT = 1
) (
   input  logic          clk,
   input  logic          rst,
   neuron_mac_if.slave   bus
);
   localparam int             IW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]  IDX_LAST = IW'(N-1);

   state_e               r_state;
   state_e               w_next_state;
   logic [N*W-1:0]       r_x;
   logic [N*W-1:0]       r_w;
   logic signed [M-1:0]  r_acc;
   logic signed [M-1:0]  r_result;
   logic [IW-1:0]        r_idx;
   logic                 r_valid;
   logic                 w_busy;
   logic signed [W-1:0]  w_xi;
   logic signed [W-1:0]  w_wi;
   logic signed [M-1:0]  w_sum;
   logic signed [M-1:0]  w_act;

   assign w_xi = r_x[int'(r_idx)*W +: W];
   assign w_wi = r_w[int'(r_idx)*W +: W];

   mac_sat_add #(.W(W), .M(M)) u_sat_add (
      .i_acc (r_acc),
      .i_x   (w_xi),
      .i_w   (w_wi),
      .o_sum (w_sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; start is only looked at while idle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next_state = ST_MAC;
            else           w_next_state = ST_IDLE;
         end
         ST_MAC: begin
            if (r_idx == IDX_LAST) w_next_state = ST_OUT;
            else                   w_next_state = ST_MAC;
         end
         ST_OUT:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      w_busy = 1'b0;
      case (r_state)
         ST_MAC:  w_busy = 1'b1;
         ST_OUT:  w_busy = 1'b1;
         default: w_busy = 1'b0;
      endcase
   end

   // Activation applied to the final accumulator.
   always_comb begin
      w_act = r_acc;
      if ((ACT == 1) && r_acc[M-1]) begin
         w_act = {M{1'b0}};
      end else begin
         w_act = r_acc;
      end
   end

   // Operand capture, accumulation, index counter and result/valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= {(N*W){1'b0}};
         r_w      <= {(N*W){1'b0}};
         r_acc    <= {M{1'b0}};
         r_idx    <= {IW{1'b0}};
         r_result <= {M{1'b0}};
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_x   <= bus.x_flat;
                  r_w   <= bus.w_flat;
                  r_acc <= bus.bias;
                  r_idx <= {IW{1'b0}};
               end
            end
            ST_MAC: begin
               r_acc <= w_sum;
               r_idx <= r_idx + IW'(1);
            end
            ST_OUT: begin
               r_result <= w_act;
               r_valid  <= 1'b1;
            end
            default: r_valid <= 1'b0;
         endcase
      end
   end

   assign bus.busy   = w_busy;
   assign bus.valid  = r_valid;
   assign bus.result = r_result;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench: a ReLU and an identity instance driven with identical
// stimulus and compared against hand-computed results.
module tb_neuron_mac;
   localparam int N = 4;
   localparam int W = 8;
   localparam int M = 18;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   neuron_mac_if #(.N(N), .W(W), .M(M)) ir ();
   neuron_mac_if #(.N(N), .W(W), .M(M)) il ();

   neuron_mac #(.N(N), .W(W), .M(M), .ACT(1)) u_relu (.clk(clk), .rst(rst), .bus(ir));
   neuron_mac #(.N(N), .W(W), .M(M), .ACT(0)) u_lin  (.clk(clk), .rst(rst), .bus(il));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      ir.start = v;
      il.start = v;
   endtask

   task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3, input int bs);
      logic [31:0] xv;
      logic [31:0] wv;
      logic [31:0] bv;
      xv = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
      wv = {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
      bv = bs;
      ir.x_flat = xv;  il.x_flat = xv;
      ir.w_flat = wv;  il.w_flat = wv;
      ir.bias = bv[M-1:0];
      il.bias = bv[M-1:0];
   endtask

   // Issues one start from an idle cycle and follows the job to its valid cycle.
   task automatic do_op(input string tag, input int exp_r, input int exp_l, input bit scramble);
      int k;
      int bc;
      set_start(1'b1);
      tick();
      set_start(1'b0);
      if (scramble) set_ops(127, 127, 127, 127, 127, 127, 127, 127, 5);
      chk({tag, "_busy_first"}, ir.busy, 1);
      chk({tag, "_valid_first"}, ir.valid, 0);
      k  = 1;
      bc = 1;
      while (!ir.valid && k < 20) begin
         tick();
         k++;
         if (!ir.valid && ir.busy) bc++;
      end
      chk({tag, "_latency"}, k, N + 2);
      chk({tag, "_busy_cycles"}, bc, N + 1);
      chk({tag, "_valid_lin"}, il.valid, 1);
      chk({tag, "_busy_at_valid"}, ir.busy, 0);
      chk({tag, "_res_relu"}, ir.result, exp_r);
      chk({tag, "_res_lin"}, il.result, exp_l);
   endtask

   initial begin
      int nv;
      int last;
      n_checks = 0;
      n_errors = 0;

      rst = 1'b1;
      set_start(1'b1);
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 10);
      tick();
      tick();
      chk("rst_busy", ir.busy, 0);
      chk("rst_valid", ir.valid, 0);
      chk("rst_result", ir.result, 0);
      rst = 1'b0;
      set_start(1'b0);
      tick();
      tick();
      chk("idle_busy", ir.busy, 0);
      chk("idle_valid", il.valid, 0);
      chk("idle_result", il.result, 0);

      // 10 + 5 + 12 + 21 + 32 = 80
      do_op("basic", 80, 80, 1'b0);
      // Back-to-back from the valid cycle: -90 + 6 + 0 - 4 = -88
      set_ops(-10, 2, 0, 1, 9, 3, 5, -4, 0);
      do_op("sign", 0, -88, 1'b0);
      set_ops(127, 127, 127, 127, 127, 127, 127, 127, 131000);
      do_op("sat_pos", 131071, 131071, 1'b0);
      set_ops(127, 127, 127, 127, -128, -128, -128, -128, -131000);
      do_op("sat_neg", 0, -131072, 1'b0);

      // Start held high: one result every N+2 cycles.
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 10);
      set_start(1'b1);
      nv   = 0;
      last = 0;
      for (int i = 1; i <= 3 * (N + 2); i++) begin
         tick();
         if (ir.valid) begin
            nv++;
            chk("held_result", ir.result, 80);
            if (last != 0) chk("held_gap", i - last, N + 2);
            last = i;
         end
      end
      set_start(1'b0);
      chk("held_count", nv, 3);
      tick();
      chk("held_valid_drop", ir.valid, 0);

      // Operands changed right after start must not matter.
      set_ops(1, 2, 3, 4, 5, 6, 7, 8, 10);
      do_op("latch", 80, 80, 1'b1);
      tick();

      // Reset during MAC step 2 aborts the job.
      set_start(1'b1);
      tick();
      set_start(1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", ir.busy, 0);
      chk("abort_valid", ir.valid, 0);
      chk("abort_result_relu", ir.result, 0);
      chk("abort_result_lin", il.result, 0);
      nv = 0;
      for (int i = 0; i < 2 * (N + 2); i++) begin
         tick();
         if (ir.valid || il.valid) nv++;
      end
      chk("abort_no_valid", nv, 0);

      set_ops(2, -3, 4, -5, 6, 7, -8, 9, -1);
      // -1 + 12 - 21 - 32 - 45 = -87
      do_op("recover", 0, -87, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
